// File: rtl/sevenseg_reader.sv
// rtl/sevenseg_reader.sv - recovers packed BCD frames from a multiplexed seven-segment bus
module sevenseg_reader #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [6:0]            seg,
    input  logic [DIGITS-1:0]     an,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   dout,
    output logic                  frame_err,
    output logic                  overrun
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
    // Counter value seen just before the STABLE_CYCLES-th identical sample
    localparam logic [CW-1:0] CNT_ARM = CW'((STABLE_CYCLES >= 2) ? (STABLE_CYCLES - 2) : 0);

    logic [DIGITS-1:0]   prev_an;
    logic [6:0]          prev_seg;
    logic [CW-1:0]       cnt;
    logic [DIGITS-1:0]   mask;
    logic [4*DIGITS-1:0] digits;
    logic                err_acc;

    logic                an_onehot;
    logic                same;
    logic                capture;
    logic                frame_done;
    logic [3:0]          dec_digit;
    logic                dec_illegal;
    logic [DIGITS-1:0]   mask_next;
    logic                err_next;
    logic [CW-1:0]       cnt_next;

    // Segment pattern to BCD; anything unrecognised becomes F and is flagged
    always_comb begin
        dec_illegal = 1'b0;
        case (seg)
            7'h7E:   dec_digit = 4'd0;
            7'h30:   dec_digit = 4'd1;
            7'h6D:   dec_digit = 4'd2;
            7'h79:   dec_digit = 4'd3;
            7'h33:   dec_digit = 4'd4;
            7'h5B:   dec_digit = 4'd5;
            7'h5F:   dec_digit = 4'd6;
            7'h70:   dec_digit = 4'd7;
            7'h7F:   dec_digit = 4'd8;
            7'h7B:   dec_digit = 4'd9;
            default: begin
                dec_digit   = 4'hF;
                dec_illegal = 1'b1;
            end
        endcase
    end

    // Stability tracking and capture decision; mask all-ones is the one-cycle COMPLETE state
    always_comb begin
        an_onehot  = (an != '0) && ((an & (an - DIGITS'(1))) == '0);
        same       = ({an, seg} == {prev_an, prev_seg});
        capture    = an_onehot && ((STABLE_CYCLES == 1) || (same && (cnt == CNT_ARM)));
        frame_done = &mask;
        if (same && an_onehot) begin
            cnt_next = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
        end else begin
            cnt_next = '0;
        end
        mask_next = (frame_done ? '0 : mask) | (capture ? an : '0);
        err_next  = (frame_done ? 1'b0 : err_acc) | (capture & dec_illegal);
    end

    // Input sampling, stability counter, frame assembly
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_an  <= '0;
            prev_seg <= '0;
            cnt      <= '0;
            mask     <= '0;
            digits   <= '0;
            err_acc  <= 1'b0;
        end else begin
            prev_an  <= an;
            prev_seg <= seg;
            cnt      <= cnt_next;
            mask     <= mask_next;
            err_acc  <= err_next;
            for (int i = 0; i < DIGITS; i++) begin
                if (capture && an[i]) begin
                    digits[4*i +: 4] <= dec_digit;
                end
            end
        end
    end

    // Output holding register with valid/ready handshake and sticky overrun
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            dout      <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else if (frame_done) begin
            if (!out_valid || out_ready) begin
                dout      <= digits;
                frame_err <= err_acc;
                out_valid <= 1'b1;
            end else begin
                overrun   <= 1'b1;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sevenseg_reader.sv
// tb/tb_sevenseg_reader.sv - directed self-checking bench for sevenseg_reader
module tb_sevenseg_reader;

    logic        clk;
    logic        reset;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] dout;
    logic        frame_err;
    logic        overrun;

    int checks;
    int failures;

    sevenseg_reader #(.DIGITS(4), .STABLE_CYCLES(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .seg       (seg),
        .an        (an),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  s0;
        logic [6:0]  s1;
        logic [6:0]  s2;
        logic [6:0]  s3;
        logic [15:0] exp_dout;
        logic        exp_err;
    } frame_vec_t;

    frame_vec_t vecs [7];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] a, input logic [6:0] s, input int n);
        an  = a;
        seg = s;
        repeat (n) step();
    endtask

    task automatic scan4(input logic [6:0] s0, input logic [6:0] s1,
                         input logic [6:0] s2, input logic [6:0] s3);
        drive(4'b0001, s0, 3);
        drive(4'b0010, s1, 3);
        drive(4'b0100, s2, 3);
        drive(4'b1000, s3, 3);
        an  = 4'b0000;
        seg = 7'h00;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        out_ready = 1'b1;
        an        = 4'b0000;
        seg       = 7'h00;

        vecs[0] = '{7'h79, 7'h30, 7'h6D, 7'h7F, 16'h8213, 1'b0};
        vecs[1] = '{7'h79, 7'h30, 7'h00, 7'h7F, 16'h8F13, 1'b1};
        vecs[2] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 16'h3210, 1'b0};
        vecs[3] = '{7'h33, 7'h5B, 7'h5F, 7'h70, 16'h7654, 1'b0};
        vecs[4] = '{7'h7F, 7'h7B, 7'h7E, 7'h7E, 16'h0098, 1'b0};
        vecs[5] = '{7'h7E, 7'h08, 7'h7E, 7'h7E, 16'h00F0, 1'b1};
        vecs[6] = '{7'h7C, 7'h7E, 7'h7E, 7'h7E, 16'h000F, 1'b1};

        repeat (2) step();
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_dout", 32'(dout), 32'd0);
        check("reset_err", 32'(frame_err), 32'd0);
        check("reset_overrun", 32'(overrun), 32'd0);
        reset = 1'b0;
        step();

        for (int i = 0; i < 7; i++) begin
            scan4(vecs[i].s0, vecs[i].s1, vecs[i].s2, vecs[i].s3);
            check($sformatf("vec%0d_not_early", i), 32'(out_valid), 32'd0);
            step();
            check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("vec%0d_dout", i), 32'(dout), 32'(vecs[i].exp_dout));
            check($sformatf("vec%0d_err", i), 32'(frame_err), 32'(vecs[i].exp_err));
            step();
            check($sformatf("vec%0d_one_cycle", i), 32'(out_valid), 32'd0);
        end

        drive(4'b0001, 7'h79, 2);
        drive(4'b0001, 7'h7F, 1);
        drive(4'b0001, 7'h79, 3);
        drive(4'b0010, 7'h30, 3);
        drive(4'b0010, 7'h7F, 2);
        drive(4'b0100, 7'h6D, 3);
        drive(4'b1000, 7'h7F, 3);
        an = 4'b0000;
        step();
        check("glitch_valid", 32'(out_valid), 32'd1);
        check("glitch_dout", 32'(dout), 32'h8213);
        check("glitch_err", 32'(frame_err), 32'd0);
        step();

        out_ready = 1'b0;
        scan4(7'h6D, 7'h30, 7'h7E, 7'h7E);
        step();
        check("hold_first_valid", 32'(out_valid), 32'd1);
        check("hold_first_dout", 32'(dout), 32'h0012);
        check("hold_no_overrun", 32'(overrun), 32'd0);
        scan4(7'h33, 7'h79, 7'h7E, 7'h7E);
        step();
        check("drop_overrun", 32'(overrun), 32'd1);
        check("drop_valid", 32'(out_valid), 32'd1);
        check("drop_dout_held", 32'(dout), 32'h0012);
        check("drop_err_held", 32'(frame_err), 32'd0);
        out_ready = 1'b1;
        step();
        check("accept_valid_low", 32'(out_valid), 32'd0);
        repeat (3) step();
        check("accept_stays_low", 32'(out_valid), 32'd0);
        check("overrun_sticky", 32'(overrun), 32'd1);

        reset = 1'b1;
        step();
        reset = 1'b0;
        check("reset2_overrun", 32'(overrun), 32'd0);

        drive(4'b0011, 7'h30, 10);
        drive(4'b0000, 7'h30, 10);
        check("multihot_no_valid", 32'(out_valid), 32'd0);
        drive(4'b0010, 7'h30, 3);
        drive(4'b0100, 7'h6D, 3);
        drive(4'b1000, 7'h7F, 3);
        an = 4'b0000;
        repeat (3) step();
        check("multihot_mask_clean", 32'(out_valid), 32'd0);
        drive(4'b0001, 7'h79, 3);
        an = 4'b0000;
        step();
        check("multihot_complete_valid", 32'(out_valid), 32'd1);
        check("multihot_complete_dout", 32'(dout), 32'h8213);
        step();

        drive(4'b0001, 7'h5B, 3);
        drive(4'b0010, 7'h5F, 3);
        drive(4'b0100, 7'h70, 3);
        an    = 4'b0000;
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midreset_valid", 32'(out_valid), 32'd0);
        check("midreset_overrun", 32'(overrun), 32'd0);
        drive(4'b1000, 7'h79, 3);
        an = 4'b0000;
        repeat (3) step();
        check("midreset_partial_discarded", 32'(out_valid), 32'd0);
        drive(4'b0001, 7'h7B, 3);
        drive(4'b0010, 7'h7F, 3);
        drive(4'b0100, 7'h33, 3);
        an = 4'b0000;
        step();
        check("midreset_frame_valid", 32'(out_valid), 32'd1);
        check("midreset_frame_dout", 32'(dout), 32'h3489);
        check("midreset_frame_err", 32'(frame_err), 32'd0);
        check("midreset_frame_overrun", 32'(overrun), 32'd0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
